// File: rtl/calc_sequencer.sv
// calc_sequencer: debounces shape codes into tokens and sequences "A op B" through the calculator.
// Define CALC_TIMEOUT_EN to abandon partial expressions idle for TIMEOUT_CYCLES.
module calc_sequencer #(
  parameter int STABLE_CYCLES = 4
`ifdef CALC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shape_valid,
  input  logic [3:0] shape_code,
  output logic [3:0] shape_1,
  output logic [3:0] shape_2,
  output logic [1:0] shape_sym,
  input  logic [3:0] result_1,
  input  logic [3:0] result_2,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       disp_neg,
  output logic       result_valid,
  output logic [2:0] state,
  output logic       tok_accept,
  output logic       tok_err
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic [2:0] {S_A = 3'd0, S_SYM = 3'd1, S_B = 3'd2, S_CALC = 3'd3, S_SHOW = 3'd4} state_t;
  state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [3:0] r_prev_code, r_a, r_b, w_a_n, w_b_n, r_s1, r_s2, r_disp_tens, r_disp_ones;
  logic [1:0] r_sym, w_sym_n, w_op;
  logic r_prev_valid, r_armed, r_disp_neg, r_result_valid;
  logic w_run, w_is_dig, w_is_op, w_is_clr, w_acc, w_err, w_swap, w_to;
  assign w_run = shape_valid && r_prev_valid && shape_code == r_prev_code;
  assign w_cnt = !shape_valid ? '0 : !w_run ? CW'(1) :
                 (r_cnt == CW'(STABLE_CYCLES)) ? r_cnt : r_cnt + CW'(1);
  assign w_is_dig = shape_code <= 4'd9;
  assign w_is_op = shape_code inside {4'hA, 4'hB, 4'hC};
  assign w_is_clr = shape_code == 4'hF;
  assign w_op = 2'(shape_code - 4'd9);
  assign w_acc = r_armed && w_cnt == CW'(STABLE_CYCLES) && (w_is_dig || w_is_op || w_is_clr);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_valid <= 1'b0;
      r_prev_code <= '0;
      r_cnt <= '0;
      r_armed <= 1'b1;
    end else begin
      r_prev_valid <= shape_valid;
      r_prev_code <= shape_code;
      r_cnt <= w_cnt;
      r_armed <= w_acc ? 1'b0 : !w_run ? 1'b1 : r_armed;
    end
  end
`ifdef CALC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to;
  assign w_to = (r_state == S_SYM || r_state == S_B) && !w_acc && r_to == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) r_to <= '0;
    else r_to <= (w_acc || !(r_state == S_SYM || r_state == S_B)) ? '0 : r_to + TW'(1);
  end
`else
  assign w_to = 1'b0;
`endif
  always_comb begin
    w_state_n = r_state;
    w_a_n = r_a;
    w_b_n = r_b;
    w_sym_n = r_sym;
    w_err = 1'b0;
    w_swap = 1'b0;
    if (w_acc && w_is_clr) begin
      w_state_n = S_A;
      w_a_n = '0;
      w_b_n = '0;
      w_sym_n = '0;
    end else if (w_acc) begin
      case (r_state)
        S_A: if (w_is_dig) begin
          w_a_n = shape_code;
          w_state_n = S_SYM;
        end else w_err = 1'b1;
        S_SYM: if (w_is_dig) w_a_n = shape_code;
        else begin
          w_sym_n = w_op;
          w_state_n = S_B;
        end
        S_B: if (w_is_dig) begin
          w_b_n = shape_code;
          w_state_n = S_CALC;
          w_swap = r_sym == 2'b10 && shape_code > r_a;
        end else w_sym_n = w_op;
        S_CALC: w_state_n = S_SHOW;
        S_SHOW: if (w_is_dig) begin
          w_a_n = shape_code;
          w_sym_n = 2'b00;
          w_state_n = S_SYM;
        end else w_err = 1'b1;
        default: w_state_n = S_A;
      endcase
    end else if (w_to) begin
      w_state_n = S_A;
      w_a_n = '0;
      w_b_n = '0;
      w_sym_n = '0;
      w_err = 1'b1;
    end else if (r_state == S_CALC) w_state_n = S_SHOW;
    else if (r_state > S_SHOW) w_state_n = S_A;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_A;
      r_a <= '0;
      r_b <= '0;
      r_sym <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_disp_tens <= '0;
      r_disp_ones <= '0;
      r_disp_neg <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_a <= w_a_n;
      r_b <= w_b_n;
      r_sym <= w_sym_n;
      // rejected tokens leave the calculator operands untouched
      if ((w_acc && !w_err) || w_to) begin
        r_s1 <= w_swap ? w_b_n : w_a_n;
        r_s2 <= w_swap ? w_a_n : w_b_n;
      end
      if (w_acc && w_is_clr) begin
        r_disp_tens <= '0;
        r_disp_ones <= '0;
        r_disp_neg <= 1'b0;
        r_result_valid <= 1'b0;
      end else if (r_state == S_CALC) begin
        r_disp_tens <= result_1;
        r_disp_ones <= result_2;
        r_disp_neg <= r_sym == 2'b10 && r_b > r_a;
        r_result_valid <= 1'b1;
      end else if (w_acc && w_is_dig && r_state == S_SHOW) r_result_valid <= 1'b0;
    end
  end
  assign shape_1 = r_s1;
  assign shape_2 = r_s2;
  assign shape_sym = r_sym;
  assign disp_tens = r_disp_tens;
  assign disp_ones = r_disp_ones;
  assign disp_neg = r_disp_neg;
  assign result_valid = r_result_valid;
  assign state = r_state;
  assign tok_accept = w_acc;
  assign tok_err = w_err;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed plan scenarios plus random token streams against a token-level model.
module tb_calc_sequencer;
  localparam int STABLE = 4;
  localparam int TO = 100;
  logic clk = 1'b0, rst_n = 1'b0, shape_valid = 1'b0;
  logic [3:0] shape_code = '0;
  logic [3:0] shape_1, shape_2, result_1, result_2, disp_tens, disp_ones;
  logic [1:0] shape_sym;
  logic disp_neg, result_valid, tok_accept, tok_err;
  logic [2:0] state;
  int checks = 0, errors = 0, n_acc = 0, n_err = 0;
  int m_st, m_a, m_b, m_sym, m_s1, m_s2, m_dt, m_do, m_neg, m_rv, m_idle;
  always #5 clk = ~clk;
  function automatic int calc(input int s1, input int s2, input int sym);
    int v;
    v = sym == 1 ? s1 + s2 : sym == 2 ? s1 - s2 : sym == 3 ? s1 * s2 : 0;
    return v < 0 ? -v : v;
  endfunction
  assign result_1 = 4'(calc(shape_1, shape_2, shape_sym) / 10);
  assign result_2 = 4'(calc(shape_1, shape_2, shape_sym) % 10);
  calc_sequencer #(.STABLE_CYCLES(STABLE)
`ifdef CALC_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .shape_valid(shape_valid), .shape_code(shape_code),
    .shape_1(shape_1), .shape_2(shape_2), .shape_sym(shape_sym),
    .result_1(result_1), .result_2(result_2),
    .disp_tens(disp_tens), .disp_ones(disp_ones), .disp_neg(disp_neg),
    .result_valid(result_valid), .state(state), .tok_accept(tok_accept), .tok_err(tok_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_zero();
    m_st = 0; m_a = 0; m_b = 0; m_sym = 0; m_s1 = 0; m_s2 = 0;
    m_dt = 0; m_do = 0; m_neg = 0; m_rv = 0; m_idle = 0;
  endtask
  function automatic bit legal(input int c);
    return c <= 9 || c == 10 || c == 11 || c == 12 || c == 15;
  endfunction
  task automatic apply(input int c);
    int ost;
    bit sw;
    ost = m_st;
    sw = 1'b0;
    if (c == 15) begin
      model_zero();
      return;
    end
    if (c > 9 && (ost == 0 || ost == 4)) return;
    if (c <= 9 && ost == 2) begin
      m_b = c;
      m_st = 3;
      sw = m_sym == 2 && m_b > m_a;
    end else if (c <= 9) begin
      m_a = c;
      m_st = 1;
      if (ost == 4) begin
        m_sym = 0;
        m_rv = 0;
      end
    end else begin
      m_sym = c - 9;
      m_st = 2;
    end
    m_s1 = sw ? m_b : m_a;
    m_s2 = sw ? m_a : m_b;
  endtask
  task automatic cycle(input logic v, input logic [3:0] c, input bit acc);
    bit err, to;
    int ost, val;
    @(posedge clk);
    #1;
    shape_valid = v;
    shape_code = c;
    @(negedge clk);
    err = acc && c > 9 && c != 15 && (m_st == 0 || m_st == 4);
    to = 1'b0;
`ifdef CALC_TIMEOUT_EN
    to = !acc && (m_st == 1 || m_st == 2) && m_idle == TO - 1;
`endif
    check("tok_accept", tok_accept, acc);
    check("tok_err", tok_err, err || to);
    check("state", state, m_st);
    check("shape_1", shape_1, m_s1);
    check("shape_2", shape_2, m_s2);
    check("shape_sym", shape_sym, m_sym);
    check("disp_tens", disp_tens, m_dt);
    check("disp_ones", disp_ones, m_do);
    check("disp_neg", disp_neg, m_neg);
    check("result_valid", result_valid, m_rv);
    n_acc += int'(tok_accept);
    n_err += int'(tok_err);
    ost = m_st;
    if (m_st == 3) begin
      val = calc(m_s1, m_s2, m_sym);
      m_dt = val / 10;
      m_do = val % 10;
      m_neg = int'(m_sym == 2 && m_b > m_a);
      m_rv = 1;
      m_st = 4;
    end else if (acc) apply(c);
    else if (to) begin
      m_st = 0; m_a = 0; m_b = 0; m_sym = 0; m_s1 = 0; m_s2 = 0;
    end
    m_idle = (acc || !(ost == 1 || ost == 2)) ? 0 : m_idle + 1;
  endtask
  task automatic present(input int c, input int hold, input int gap);
    for (int k = 1; k <= hold; k++) cycle(1'b1, 4'(c), k == STABLE && legal(c));
    for (int k = 0; k < gap; k++) cycle(1'b0, 4'd0, 1'b0);
  endtask
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    shape_valid = 1'b0;
    shape_code = '0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_outs"}, {shape_1, shape_2, shape_sym, disp_tens, disp_ones, disp_neg,
                            result_valid, tok_accept, tok_err}, 0);
    check({tag, "_state"}, state, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_zero();
  endtask
  initial begin
    int last, lg, c, h, g;
    model_zero();
    do_reset("rst0");
    present(7, 6, 2); present(12, 6, 2); present(9, 6, 2);
    check("t1_s1", shape_1, 7); check("t1_s2", shape_2, 9); check("t1_sym", shape_sym, 3);
    check("t1_tens", disp_tens, 6); check("t1_ones", disp_ones, 3);
    check("t1_neg", disp_neg, 0); check("t1_rv", result_valid, 1);
    present(3, 6, 2); present(11, 6, 2); present(8, 6, 2);
    check("t2_s1", shape_1, 8); check("t2_s2", shape_2, 3); check("t2_sym", shape_sym, 2);
    check("t2_tens", disp_tens, 0); check("t2_ones", disp_ones, 5); check("t2_neg", disp_neg, 1);
    n_acc = 0;
    present(5, 3, 2);
    check("t3_short", n_acc, 0);
    present(5, 20, 2);
    check("t3_long", n_acc, 1);
    present(5, 6, 0); present(6, 6, 2);
    check("t3_pair", n_acc, 3);
    present(15, 5, 2);
    check("clr_state", state, 0); check("clr_rv", result_valid, 0);
    n_err = 0;
    present(10, 6, 2);
    check("t4_err_sa", n_err, 1); check("t4_state_sa", state, 0);
    present(4, 6, 2); present(10, 6, 2); present(11, 6, 2); present(2, 6, 2);
    check("t4_sym", shape_sym, 2); check("t4_tens", disp_tens, 0); check("t4_ones", disp_ones, 2);
    n_err = 0;
    present(12, 6, 2);
    check("t4_err_show", n_err, 1); check("t4_hold", disp_ones, 2); check("t4_st", state, 4);
    present(6, 6, 2); present(10, 6, 2); present(15, 6, 2);
    check("t5_state", state, 0); check("t5_shapes", {shape_1, shape_2, shape_sym}, 0);
    check("t5_rv", result_valid, 0);
    present(6, 6, 2); present(10, 6, 2);
    check("t5_in_sb", state, 2);
    do_reset("t5_rst");
    present(1, 6, 2); present(10, 6, 2);
    n_err = 0;
    for (int k = 0; k < 110; k++) cycle(1'b0, 4'd0, 1'b0);
`ifdef CALC_TIMEOUT_EN
    check("t6_state", state, 0); check("t6_err", n_err, 1);
`else
    check("t6_state", state, 2); check("t6_err", n_err, 0);
`endif
    do_reset("rnd_rst");
    last = -1;
    lg = 1;
    for (int i = 0; i < 250; i++) begin
      c = int'($urandom_range(0, 15));
      if (lg == 0 && c == last) c = (c + 1) % 16;
      h = int'($urandom_range(1, 9));
      g = int'($urandom_range(0, 3));
      present(c, h, g);
      last = c;
      lg = g;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
